// File: rtl/therm_pkg.sv
// Shared types, FSM encoding and the Beta-model LUT for the thermistor converter.
// LUT points are Q.4 degC at codes k*2**(ADC_W-SEG_BITS), thermistor on the low side of a 10k divider.
package therm_pkg;

  localparam int TEMP_FRAC    = 4;
  localparam int TEMP_BITS    = 16;
  localparam int LUT_SEG_BITS = 4;
  localparam int LUT_N        = (1 << LUT_SEG_BITS) + 1;

  typedef logic signed [TEMP_BITS-1:0] temp_t;

  typedef enum logic [2:0] {IDLE, FETCH, INTERP, HOLD, AVG} state_t;

  // Beta 3539, R0 2000 ohm @ 25 C. Rail codes mean a shorted or open sensor,
  // so the end points are pinned at +125 C and -100 C instead of the diverging model.
  localparam temp_t THERM_LUT [LUT_N] = '{
    16'sd2000,  16'sd887,   16'sd539,   16'sd343,
    16'sd203,   16'sd91,   -16'sd4,    -16'sd90,
   -16'sd170,  -16'sd246,  -16'sd323,  -16'sd402,
   -16'sd486,  -16'sd582,  -16'sd700,  -16'sd872,
   -16'sd1600
  };

  function automatic temp_t lut_interp_ref(input logic [11:0] code);
    int idx;
    int frac;
    int lo;
    int hi;
    int prod;
    idx  = int'({28'd0, code[11:8]});
    frac = int'({24'd0, code[7:0]});
    lo   = int'(THERM_LUT[idx]);
    hi   = int'(THERM_LUT[idx+1]);
    prod = (hi - lo) * frac;
    return temp_t'(lo + (prod >>> 8));
  endfunction

endpackage

// File: rtl/therm_lut_interp.sv
// Two-stage LUT read and linear interpolation: segment end points registered on rd_vld,
// interpolated temperature registered one cycle later and held until the next read.
module therm_lut_interp
  import therm_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int SEG_BITS = LUT_SEG_BITS,
  parameter int TEMP_W   = TEMP_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_vld,
  input  logic [SEG_BITS-1:0]           idx,
  input  logic [ADC_W-SEG_BITS-1:0]     frac,
  output logic signed [TEMP_W-1:0]      temp
);

  localparam int F  = ADC_W - SEG_BITS;
  localparam int PW = TEMP_W + 1 + F;

  logic signed [TEMP_W-1:0] lo_q, lo_d, hi_q, hi_d, temp_q, temp_d;
  logic [F-1:0]             frac_q, frac_d;
  logic                     s1_vld_q, s1_vld_d;
  logic [SEG_BITS:0]        idx_lo, idx_hi;
  logic signed [TEMP_W:0]   delta;
  logic signed [PW-1:0]     prod, step, sum_full;
  logic                     unused_sum_hi;

  always_comb begin
    idx_lo   = {1'b0, idx};
    idx_hi   = idx_lo + {{SEG_BITS{1'b0}}, 1'b1};
    lo_d     = lo_q;
    hi_d     = hi_q;
    frac_d   = frac_q;
    s1_vld_d = rd_vld;
    temp_d   = temp_q;
    if (rd_vld) begin
      lo_d   = THERM_LUT[idx_lo];
      hi_d   = THERM_LUT[idx_hi];
      frac_d = frac;
    end
    // Full-precision signed product; the shift floors toward -inf.
    delta    = {hi_q[TEMP_W-1], hi_q} - {lo_q[TEMP_W-1], lo_q};
    prod     = $signed({{F{delta[TEMP_W]}}, delta}) * $signed({{(TEMP_W+1){1'b0}}, frac_q});
    step     = prod >>> F;
    sum_full = $signed({{(F+1){lo_q[TEMP_W-1]}}, lo_q}) + step;
    if (s1_vld_q) begin
      temp_d = sum_full[TEMP_W-1:0];
    end
  end

  assign unused_sum_hi = ^sum_full[PW-1:TEMP_W];
  assign temp          = temp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q     <= '0;
      hi_q     <= '0;
      frac_q   <= '0;
      s1_vld_q <= 1'b0;
      temp_q   <= '0;
    end else begin
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      frac_q   <= frac_d;
      s1_vld_q <= s1_vld_d;
      temp_q   <= temp_d;
    end
  end

endmodule

// File: rtl/thermistor_temp_conv.sv
// NTC ADC code -> Q.4 degC, per-channel alarm; THERM_AVG_EN adds a 4-deep per-channel average.
// Accept->out_valid 3 cycles (4 averaged); one sample in flight, in_ready low until the result is taken.
module thermistor_temp_conv
  import therm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADC_W    = 12,
  parameter int SEG_BITS = LUT_SEG_BITS,
  parameter int TEMP_W   = TEMP_BITS,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [ADC_W-1:0]         in_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [TEMP_W-1:0] out_temp,
  input  logic signed [TEMP_W-1:0] alarm_thresh,
  output logic [NUM_CH-1:0]        alarm,
  output logic                     err_ch
);

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [ADC_W-1:0]    code_q, code_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [NUM_CH-1:0]   alarm_q, alarm_d;
  logic                err_ch_q, err_ch_d;
  logic                ch_ok;
  logic signed [TEMP_W-1:0] interp_temp;

  therm_lut_interp #(.ADC_W(ADC_W), .SEG_BITS(SEG_BITS), .TEMP_W(TEMP_W)) u_interp (
    .clk    (clk),
    .rst    (rst),
    .rd_vld (state_q == FETCH),
    .idx    (code_q[ADC_W-1 -: SEG_BITS]),
    .frac   (code_q[ADC_W-SEG_BITS-1:0]),
    .temp   (interp_temp)
  );

  always_comb begin
    ch_ok       = ({{(32-CH_W){1'b0}}, in_ch} < NUM_CH);
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    code_d      = code_q;
    out_ch_d    = out_ch_q;
    alarm_d     = alarm_q;
    err_ch_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (ch_ok) begin
            state_d    = FETCH;
            in_ready_d = 1'b0;
            code_d     = in_code;
            out_ch_d   = in_ch;
          end else begin
            err_ch_d = 1'b1;
          end
        end
      end
      FETCH: state_d = INTERP;
      INTERP: begin
`ifdef THERM_AVG_EN
        state_d = AVG;
`else
        state_d     = HOLD;
        out_valid_d = 1'b1;
`endif
      end
      AVG: begin
        state_d     = HOLD;
        out_valid_d = 1'b1;
      end
      HOLD: begin
        if (out_ready) begin
          state_d           = IDLE;
          out_valid_d       = 1'b0;
          in_ready_d        = 1'b1;
          alarm_d[out_ch_q] = (out_temp >= alarm_thresh);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      code_q      <= '0;
      out_ch_q    <= '0;
      alarm_q     <= '0;
      err_ch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      out_ch_q    <= out_ch_d;
      alarm_q     <= alarm_d;
      err_ch_q    <= err_ch_d;
    end
  end

`ifdef THERM_AVG_EN
  logic signed [TEMP_W-1:0] hist_q [NUM_CH][4];
  logic signed [TEMP_W-1:0] hist_d [NUM_CH][4];
  logic [NUM_CH-1:0]        filled_q, filled_d;
  logic signed [TEMP_W-1:0] avg_q, avg_d;
  logic signed [TEMP_W+1:0] avg_sum;
  logic                     unused_avg_lsb;

  always_comb begin
    hist_d   = hist_q;
    filled_d = filled_q;
    avg_d    = avg_q;
    avg_sum  = '0;
    if (state_q == AVG) begin
      // First result of a channel seeds its whole window so the average starts at that value.
      for (int i = 0; i < 4; i++) begin
        if (!filled_q[out_ch_q] || i == 3) begin
          hist_d[out_ch_q][i] = interp_temp;
        end else begin
          hist_d[out_ch_q][i] = hist_q[out_ch_q][i+1];
        end
      end
      filled_d[out_ch_q] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        avg_sum = avg_sum + {{2{hist_d[out_ch_q][i][TEMP_W-1]}}, hist_d[out_ch_q][i]};
      end
      avg_d = avg_sum[TEMP_W+1:2];
    end
  end

  assign unused_avg_lsb = ^avg_sum[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < 4; i++) begin
          hist_q[c][i] <= '0;
        end
      end
      filled_q <= '0;
      avg_q    <= '0;
    end else begin
      hist_q   <= hist_d;
      filled_q <= filled_d;
      avg_q    <= avg_d;
    end
  end

  assign out_temp = avg_q;
`else
  assign out_temp = interp_temp;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign alarm     = alarm_q;
  assign err_ch    = err_ch_q;

endmodule

// File: tb/tb_thermistor_temp_conv.sv
// Self-checking bench: directed vector table, reset/abort and bad-channel sequences, random traffic vs a reference model.
module tb_thermistor_temp_conv;
  import therm_pkg::*;

`ifdef THERM_AVG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, in_ready, out_valid, out_ready, err_ch;
  logic [1:0]        in_ch, out_ch;
  logic [11:0]       in_code;
  logic signed [15:0] out_temp, alarm_thresh;
  logic [3:0]        alarm;

  logic              in_valid3, in_ready3, out_valid3, err_ch3;
  logic [1:0]        in_ch3, out_ch3;
  logic signed [15:0] out_temp3;
  logic [2:0]        alarm3;

  thermistor_temp_conv #(.NUM_CH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_temp(out_temp), .alarm_thresh(alarm_thresh), .alarm(alarm), .err_ch(err_ch)
  );

  thermistor_temp_conv #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_ch(in_ch3),
    .in_code(in_code), .out_valid(out_valid3), .out_ready(out_ready), .out_ch(out_ch3),
    .out_temp(out_temp3), .alarm_thresh(alarm_thresh), .alarm(alarm3), .err_ch(err_ch3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit [3:0] exp_alarm;
  int       hist [4][4];
  bit       filled [4];

  typedef struct {
    int ch;
    int code;
    int thresh;
    int stall;
    int exp_raw;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int floor_div(int a, int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Straight-line interpolation between the two table points bracketing the code.
  function automatic int ref_temp(int code);
    int idx, frac, lo, hi;
    idx  = code / 256;
    frac = code % 256;
    lo   = int'(THERM_LUT[idx]);
    hi   = int'(THERM_LUT[idx+1]);
    return lo + floor_div((hi - lo) * frac, 256);
  endfunction

  function automatic int model_out(int ch, int raw);
    int s;
    s = 0;
    if (!filled[ch]) begin
      for (int i = 0; i < 4; i++) hist[ch][i] = raw;
    end else begin
      for (int i = 0; i < 3; i++) hist[ch][i] = hist[ch][i+1];
      hist[ch][3] = raw;
    end
    filled[ch] = 1'b1;
    for (int i = 0; i < 4; i++) s += hist[ch][i];
`ifdef THERM_AVG_EN
    return floor_div(s, 4);
`else
    return raw;
`endif
  endfunction

  task automatic model_reset();
    exp_alarm = '0;
    for (int c = 0; c < 4; c++) begin
      filled[c] = 1'b0;
      for (int i = 0; i < 4; i++) hist[c][i] = 0;
    end
  endtask

  task automatic do_txn(input int ch, input int code, input int thresh, input int stall, input int exp_raw);
    int lat, exp_out;
    bit busy_ok, stable;
    logic signed [15:0] held;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    in_code  = 12'(code);
    @(negedge clk);
    in_valid = 1'b0;
    check("err_ch_quiet", err_ch, 0);
    exp_out = model_out(ch, exp_raw);
    lat     = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 20) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, LAT);
    check("in_ready_busy", busy_ok, 1);
    check("out_ch", out_ch, ch);
    check("out_temp", $signed(out_temp), exp_out);
    if (stall > 0) begin
      held   = out_temp;
      stable = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        if (!out_valid || out_temp != held || in_ready) stable = 1'b0;
      end
      check("backpressure_hold", stable, 1);
    end
    alarm_thresh = 16'(thresh);
    out_ready    = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_alarm[ch] = (exp_out >= thresh);
    check("out_valid_after", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("alarm", alarm, exp_alarm);
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_code = '0; out_ready = 1'b0;
    alarm_thresh = '0; in_valid3 = 1'b0; in_ch3 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_alarm", alarm, 0);
    check("rst_out_temp", $signed(out_temp), 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_err_ch", err_ch, 0);

    vecs = '{
      '{0, 12'h000,  1280,  0,  2000},
      '{1, 12'h180,   713,  0,   713},
      '{2, 12'h040,  1280, 10,  1721},
      '{2, 12'h100,  1280,  0,   887},
      '{3, 12'hFFF, -1000,  0, -1598},
      '{1, 12'h0C0,  2000,  0,  1165},
      '{0, 12'h6A5,  -100,  0,   -60}
    };
    foreach (vecs[i]) do_txn(vecs[i].ch, vecs[i].code, vecs[i].thresh, vecs[i].stall, vecs[i].exp_raw);

    // Abort a conversion while it is interpolating.
    in_valid = 1'b1; in_ch = 2'd2; in_code = 12'h040;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort_in_ready", in_ready, 1);
    check("abort_alarm_clr", alarm, 0);
    check("abort_out_temp", $signed(out_temp), 0);
    out_ready = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    out_ready = 1'b0;
    check("abort_no_result", quiet, 1);

    // Out-of-range channel on the three-channel instance.
    in_valid3 = 1'b1; in_ch3 = 2'd3; in_code = 12'h180;
    @(negedge clk);
    in_valid3 = 1'b0;
    check("err_ch_pulse", err_ch3, 1);
    check("err_in_ready", in_ready3, 1);
    @(negedge clk);
    check("err_ch_one_cycle", err_ch3, 0);
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid3) quiet = 1'b0;
    end
    check("err_no_result", quiet, 1);
    in_valid3 = 1'b1; in_ch3 = 2'd2;
    @(negedge clk);
    in_valid3 = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check("ch3dut_valid", out_valid3, 1);
    check("ch3dut_temp", $signed(out_temp3), 713);
    check("ch3dut_ch", out_ch3, 2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ch3dut_done", out_valid3, 0);

    for (int n = 0; n < 40; n++) begin
      int ch, code, thresh, stall;
      ch     = int'($urandom_range(0, 3));
      code   = int'($urandom_range(0, 4095));
      thresh = int'($urandom_range(0, 3800)) - 1700;
      stall  = int'($urandom_range(0, 3));
      do_txn(ch, code, thresh, stall, ref_temp(code));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
